instr_mem_fetch: RTL

- Parametrised, writable instruction memory with a registered, handshaked fetch port.
- Sits between the PC/fetch stage and decode.
- Adds a program-load write port, a one-entry output buffer with back-pressure, out-of-range fault reporting and a saturating fetch counter.
- Replaces the fixed 16x256 combinational-read instruction store.

---
 rtl/cpu_pkg.sv | 8 +
 rtl/instr_mem_array.sv | 25 ++
 rtl/instr_mem_fetch.sv | 109 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: default widths and the NOP encoding.
// Imported by fetch-side blocks that need a safe filler word.
package cpu_pkg;
  localparam int INSTR_W_DEF = 16;
  localparam int ADDR_W_DEF = 16;
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [15:0] NOP_DEF = {OP_NOP, 12'h000};
endpackage

// File: rtl/instr_mem_array.sv
// Synchronous-read instruction store, one write and one read port.
// rdata is held between reads so it can serve as the output buffer.
module instr_mem_array #(
  parameter int DEPTH = 256,
  parameter int INSTR_W = 16,
  parameter int AW = 8
) (
  input  logic               clock,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic               re,
  input  logic [AW-1:0]      raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [DEPTH];

  // Plain write/read ports so the storage maps onto block RAM.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/instr_mem_fetch.sv
// Writable instruction memory with a handshaked, one-entry fetch buffer,
// range fault reporting and a saturating accepted-fetch counter.
import cpu_pkg::*;

module instr_mem_fetch #(
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH = 256,
  parameter logic [INSTR_W-1:0] NOP_WORD = INSTR_W'(NOP_DEF),
  parameter int CNT_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               prog_we,
  input  logic [ADDR_W-1:0]  prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  output logic               prog_err,
  input  logic               fetch_req,
  input  logic [ADDR_W-1:0]  fetch_addr,
  output logic               fetch_ready,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  input  logic               instr_ready,
  output logic               addr_fault,
  output logic [CNT_W-1:0]   fetch_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] LIM = (ADDR_W+1)'(DEPTH);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t             state;
  logic               fetch_ok;
  logic               prog_ok;
  logic               accept;
  logic               consume;
  logic               mem_we;
  logic               mem_re;
  logic [INSTR_W-1:0] rdata;

  assign fetch_ok = {1'b0, fetch_addr} < LIM;
  assign prog_ok = {1'b0, prog_addr} < LIM;

  // A pending write blocks fetches, so reads never race a write.
  assign fetch_ready = !prog_we && (state == EMPTY || instr_ready);
  assign accept = fetch_req && fetch_ready && !reset;
  assign consume = instr_valid && instr_ready;
  assign mem_we = prog_we && prog_ok && !reset;
  assign mem_re = accept && fetch_ok;

  // The array read register is the buffer; invalid/faulted words are masked.
  assign instr = !instr_valid ? '0 : (addr_fault ? NOP_WORD : rdata);

  instr_mem_array #(
    .DEPTH(DEPTH),
    .INSTR_W(INSTR_W),
    .AW(AW)
  ) u_array (
    .clock(clock),
    .we(mem_we),
    .waddr(prog_addr[AW-1:0]),
    .wdata(prog_data),
    .re(mem_re),
    .raddr(fetch_addr[AW-1:0]),
    .rdata(rdata)
  );

  // Output-buffer FSM: EMPTY/FULL with back-to-back reload.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= EMPTY;
      instr_valid <= 1'b0;
      addr_fault <= 1'b0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            state <= FULL;
            instr_valid <= 1'b1;
            addr_fault <= !fetch_ok;
          end
        end
        FULL: begin
          if (accept) begin
            addr_fault <= !fetch_ok;
          end else if (consume) begin
            state <= EMPTY;
            instr_valid <= 1'b0;
            addr_fault <= 1'b0;
          end
        end
      endcase
    end
  end

  // One-cycle pulse for a dropped out-of-range program write.
  always_ff @(posedge clock) begin
    if (reset) prog_err <= 1'b0;
    else prog_err <= prog_we && !prog_ok;
  end

  // Accepted-fetch counter, sticks at all-ones.
  always_ff @(posedge clock) begin
    if (reset) fetch_count <= '0;
    else if (accept && fetch_count != '1) fetch_count <= fetch_count + 1'b1;
  end

endmodule
